// File: rtl/bmask_allocator_pkg.sv
// Shared types for the branch-mask allocator: mask widths, checkpoint packet
// and the completing-branch packet that drives resolve and squash.
package bmask_allocator_pkg;

    localparam int DISPATCH_WIDTH   = 2;
    localparam int B_MASK_WIDTH     = 4;
    localparam int PHYS_REG_SZ_R10K = 16;
    localparam int FREE_SLOTS_WIDTH = $clog2(B_MASK_WIDTH + 1);

    typedef logic [B_MASK_WIDTH-1:0] B_MASK;
    typedef B_MASK [B_MASK_WIDTH-1:0] B_MASK_MASK;

    typedef struct packed {
        logic [4:0]                  rob_tail;
        logic [31:0]                 recovery_pc;
        logic [31:0]                 original_pc;
        logic                        is_jump;
        logic [7:0]                  bp_packet;
        logic [15:0]                 map_table;
        logic [2:0]                  sq_tail;
        logic [7:0]                  sq_mask;
        B_MASK                       b_m;
        logic [PHYS_REG_SZ_R10K-1:0] free_list;
    } BS_ENTRY_PACKET;

    typedef struct packed {
        B_MASK bmm;
        logic  bm_mispred;
    } BRANCH_REG_PACKET;

    function automatic logic [FREE_SLOTS_WIDTH-1:0] count_ones(input B_MASK m);
        logic [FREE_SLOTS_WIDTH-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < B_MASK_WIDTH; i++) begin
            cnt = cnt + FREE_SLOTS_WIDTH'(m[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/bmask_allocator_pick_lowest.sv
// One-hot picker for the lowest set bit of a vector; chained per dispatch slot.
module bmask_pick_lowest #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] avail,
    output logic [WIDTH-1:0] pick,
    output logic             found
);

    // Two's-complement trick isolates the lowest set bit.
    assign pick  = avail & (~avail + WIDTH'(1));
    assign found = |avail;

endmodule

// File: rtl/bmask_allocator.sv
// Dispatch-side branch-mask allocator: grants one-hot checkpoint bits in program
// order, builds checkpoint packets, and tracks live bits plus their dependencies.
module bmask_allocator
    import bmask_allocator_pkg::*;
(
    input  logic                            clock,
    input  logic                            reset,
    input  logic [DISPATCH_WIDTH-1:0]       br_req,
    input  BS_ENTRY_PACKET [DISPATCH_WIDTH-1:0] br_ckpt,
    input  logic [PHYS_REG_SZ_R10K-1:0]     free_list_in,
    input  BRANCH_REG_PACKET                branch_completing,
    output logic [DISPATCH_WIDTH-1:0]       br_grant,
    output B_MASK [DISPATCH_WIDTH-1:0]      slot_b_mask,
    output B_MASK [DISPATCH_WIDTH-1:0]      slot_b_id,
    output B_MASK                           next_b_mask,
    output BS_ENTRY_PACKET [B_MASK_WIDTH-1:0] branch_stack_entries,
    output logic [FREE_SLOTS_WIDTH-1:0]     free_slots
);

    B_MASK      live_q;
    B_MASK_MASK parent_q;
    B_MASK_MASK parent_d;

    B_MASK resolve;
    B_MASK dependents;
    B_MASK squash;
    B_MASK older;
    logic  suppress;

    B_MASK avail_chain [DISPATCH_WIDTH];
    B_MASK pick        [DISPATCH_WIDTH];
    logic  found       [DISPATCH_WIDTH];
    logic  chain_ok    [DISPATCH_WIDTH];
    logic  granted_raw [DISPATCH_WIDTH];

    assign avail_chain[0] = ~live_q;
    assign chain_ok[0]    = 1'b1;

    // Once a requesting slot is denied, every later slot is denied too.
    for (genvar k = 0; k < DISPATCH_WIDTH; k++) begin : g_slot
        bmask_pick_lowest #(.WIDTH(B_MASK_WIDTH)) u_pick (
            .avail(avail_chain[k]),
            .pick (pick[k]),
            .found(found[k])
        );

        assign granted_raw[k] = br_req[k] & chain_ok[k] & found[k];

        if (k < DISPATCH_WIDTH - 1) begin : g_next
            assign chain_ok[k+1]    = chain_ok[k] & ~(br_req[k] & ~found[k]);
            assign avail_chain[k+1] = granted_raw[k] ? (avail_chain[k] & ~pick[k])
                                                     : avail_chain[k];
        end
    end

    always_comb begin
        resolve    = branch_completing.bmm & live_q;
        dependents = '0;
        for (int j = 0; j < B_MASK_WIDTH; j++) begin
            dependents[j] = |(parent_q[j] & resolve);
        end
        squash   = branch_completing.bm_mispred ? (resolve | dependents) : resolve;
        suppress = branch_completing.bm_mispred && (|resolve);

        br_grant    = '0;
        slot_b_id   = '0;
        slot_b_mask = '0;
        older       = '0;
        for (int k = 0; k < DISPATCH_WIDTH; k++) begin
            br_grant[k]    = granted_raw[k] && !suppress;
            slot_b_id[k]   = br_grant[k] ? pick[k] : '0;
            slot_b_mask[k] = (live_q & ~resolve) | older;
            older          = older | slot_b_id[k];
        end

        next_b_mask = (live_q & ~squash) | older;

        // Squashed rows vanish; surviving rows forget squashed parents.
        for (int i = 0; i < B_MASK_WIDTH; i++) begin
            parent_d[i] = squash[i] ? '0 : (parent_q[i] & ~squash);
        end

        branch_stack_entries = '0;
        for (int k = 0; k < DISPATCH_WIDTH; k++) begin
            for (int i = 0; i < B_MASK_WIDTH; i++) begin
                if (slot_b_id[k][i]) begin
                    branch_stack_entries[i]           = br_ckpt[k];
                    branch_stack_entries[i].b_m       = slot_b_mask[k];
                    branch_stack_entries[i].free_list = free_list_in;
                    parent_d[i]                       = slot_b_mask[k];
                end
            end
        end

        free_slots = count_ones(~live_q);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            live_q   <= '0;
            parent_q <= '0;
        end else begin
            live_q   <= next_b_mask;
            parent_q <= parent_d;
        end
    end

endmodule

// File: tb/tb_bmask_allocator.sv
// Table-driven scoreboard bench for bmask_allocator, plus a mid-cycle reset sequence.
module tb_bmask_allocator;
    import bmask_allocator_pkg::*;

    logic                                clock;
    logic                                reset;
    logic [DISPATCH_WIDTH-1:0]           br_req;
    BS_ENTRY_PACKET [DISPATCH_WIDTH-1:0] br_ckpt;
    logic [PHYS_REG_SZ_R10K-1:0]         free_list_in;
    BRANCH_REG_PACKET                    branch_completing;
    logic [DISPATCH_WIDTH-1:0]           br_grant;
    B_MASK [DISPATCH_WIDTH-1:0]          slot_b_mask;
    B_MASK [DISPATCH_WIDTH-1:0]          slot_b_id;
    B_MASK                               next_b_mask;
    BS_ENTRY_PACKET [B_MASK_WIDTH-1:0]   branch_stack_entries;
    logic [FREE_SLOTS_WIDTH-1:0]         free_slots;

    bmask_allocator dut (
        .clock               (clock),
        .reset               (reset),
        .br_req              (br_req),
        .br_ckpt             (br_ckpt),
        .free_list_in        (free_list_in),
        .branch_completing   (branch_completing),
        .br_grant            (br_grant),
        .slot_b_mask         (slot_b_mask),
        .slot_b_id           (slot_b_id),
        .next_b_mask         (next_b_mask),
        .branch_stack_entries(branch_stack_entries),
        .free_slots          (free_slots)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [1:0] req;
        B_MASK      bmm;
        logic       mispred;
        logic [1:0] grant;
        B_MASK      id0;
        B_MASK      id1;
        B_MASK      mask0;
        B_MASK      mask1;
        B_MASK      next;
        logic [2:0] free;
    } vec_t;

    typedef struct {
        string                             name;
        logic [1:0]                        grant;
        B_MASK [DISPATCH_WIDTH-1:0]        ids;
        B_MASK [DISPATCH_WIDTH-1:0]        masks;
        B_MASK                             next;
        logic [2:0]                        free;
        BS_ENTRY_PACKET [B_MASK_WIDTH-1:0] entries;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    task automatic add_vec(input logic [1:0] req, input B_MASK bmm, input logic mp,
                           input logic [1:0] grant, input B_MASK id0, input B_MASK id1,
                           input B_MASK m0, input B_MASK m1, input B_MASK nxt,
                           input logic [2:0] free);
        vec_t v;
        v = '{req, bmm, mp, grant, id0, id1, m0, m1, nxt, free};
        vecs.push_back(v);
    endtask

    task automatic check_value(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic apply_stimulus(input string name, input vec_t v);
        exp_t e;
        logic [127:0] rnd;
        BS_ENTRY_PACKET ent;
        @(negedge clock);
        br_req                       = v.req;
        branch_completing.bmm        = v.bmm;
        branch_completing.bm_mispred = v.mispred;
        free_list_in                 = PHYS_REG_SZ_R10K'($urandom());
        for (int k = 0; k < DISPATCH_WIDTH; k++) begin
            rnd        = {$urandom(), $urandom(), $urandom(), $urandom()};
            br_ckpt[k] = rnd[$bits(BS_ENTRY_PACKET)-1:0];
        end
        e.name     = name;
        e.grant    = v.grant;
        e.ids[0]   = v.id0;
        e.ids[1]   = v.id1;
        e.masks[0] = v.mask0;
        e.masks[1] = v.mask1;
        e.next     = v.next;
        e.free     = v.free;
        e.entries  = '0;
        for (int k = 0; k < DISPATCH_WIDTH; k++) begin
            for (int i = 0; i < B_MASK_WIDTH; i++) begin
                if (e.ids[k][i]) begin
                    ent           = br_ckpt[k];
                    ent.b_m       = e.masks[k];
                    ent.free_list = free_list_in;
                    e.entries[i]  = ent;
                end
            end
        end
        sb.push_back(e);
    endtask

    task automatic check_output();
        exp_t e;
        #1;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("[TB] FAIL scoreboard: got empty queue, expected an entry");
            return;
        end
        e = sb.pop_front();
        check_value({e.name, " br_grant"}, 32'(br_grant), 32'(e.grant));
        check_value({e.name, " slot_b_id0"}, 32'(slot_b_id[0]), 32'(e.ids[0]));
        check_value({e.name, " slot_b_id1"}, 32'(slot_b_id[1]), 32'(e.ids[1]));
        check_value({e.name, " slot_b_mask0"}, 32'(slot_b_mask[0]), 32'(e.masks[0]));
        check_value({e.name, " slot_b_mask1"}, 32'(slot_b_mask[1]), 32'(e.masks[1]));
        check_value({e.name, " next_b_mask"}, 32'(next_b_mask), 32'(e.next));
        check_value({e.name, " free_slots"}, 32'(free_slots), 32'(e.free));
        for (int i = 0; i < B_MASK_WIDTH; i++) begin
            checks++;
            if (branch_stack_entries[i] !== e.entries[i]) begin
                errors++;
                $display("[TB] FAIL %s entry%0d: got %h, expected %h",
                         e.name, i, branch_stack_entries[i], e.entries[i]);
            end
        end
    endtask

    initial begin
        reset             = 1'b0;
        br_req            = '0;
        br_ckpt           = '0;
        free_list_in      = '0;
        branch_completing = '0;

        //       req    bmm     mp    grant  id0      id1      mask0    mask1    next     free
        add_vec(2'b00, 4'b0000, 1'b0, 2'b00, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 3'd4);
        add_vec(2'b11, 4'b0000, 1'b0, 2'b11, 4'b0001, 4'b0010, 4'b0000, 4'b0001, 4'b0011, 3'd4);
        add_vec(2'b00, 4'b0000, 1'b0, 2'b00, 4'b0000, 4'b0000, 4'b0011, 4'b0011, 4'b0011, 3'd2);
        add_vec(2'b01, 4'b0001, 1'b1, 2'b00, 4'b0000, 4'b0000, 4'b0010, 4'b0010, 4'b0000, 3'd2);
        add_vec(2'b11, 4'b0000, 1'b0, 2'b11, 4'b0001, 4'b0010, 4'b0000, 4'b0001, 4'b0011, 3'd4);
        add_vec(2'b01, 4'b0001, 1'b0, 2'b01, 4'b0100, 4'b0000, 4'b0010, 4'b0110, 4'b0110, 3'd2);
        add_vec(2'b11, 4'b0000, 1'b0, 2'b11, 4'b0001, 4'b1000, 4'b0110, 4'b0111, 4'b1111, 3'd2);
        add_vec(2'b01, 4'b0000, 1'b0, 2'b00, 4'b0000, 4'b0000, 4'b1111, 4'b1111, 4'b1111, 3'd0);
        add_vec(2'b00, 4'b0001, 1'b0, 2'b00, 4'b0000, 4'b0000, 4'b1110, 4'b1110, 4'b1110, 3'd0);
        add_vec(2'b11, 4'b0000, 1'b0, 2'b01, 4'b0001, 4'b0000, 4'b1110, 4'b1111, 4'b1111, 3'd1);
        add_vec(2'b00, 4'b0000, 1'b0, 2'b00, 4'b0000, 4'b0000, 4'b1111, 4'b1111, 4'b1111, 3'd0);
        add_vec(2'b10, 4'b0010, 1'b1, 2'b00, 4'b0000, 4'b0000, 4'b1101, 4'b1101, 4'b0000, 3'd0);
        add_vec(2'b10, 4'b0000, 1'b0, 2'b10, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 3'd4);
        add_vec(2'b01, 4'b1000, 1'b1, 2'b01, 4'b0010, 4'b0000, 4'b0001, 4'b0011, 4'b0011, 3'd3);
        add_vec(2'b01, 4'b0010, 1'b0, 2'b01, 4'b0100, 4'b0000, 4'b0001, 4'b0101, 4'b0101, 3'd2);
        add_vec(2'b11, 4'b0000, 1'b0, 2'b11, 4'b0001, 4'b0010, 4'b0000, 4'b0001, 4'b0011, 3'd4);

        #1;
        check_value("reset next_b_mask", 32'(next_b_mask), 32'd0);
        check_value("reset free_slots", 32'(free_slots), 32'd4);
        check_value("reset br_grant", 32'(br_grant), 32'd0);
        @(negedge clock);
        reset = 1'b1;

        for (int n = 0; n < 15; n++) begin
            apply_stimulus($sformatf("vec%0d", n), vecs[n]);
            check_output();
        end

        // Reset asserted between edges must clear state without waiting for a clock.
        @(negedge clock);
        br_req            = '0;
        branch_completing = '0;
        #1;
        check_value("pre-reset next_b_mask", 32'(next_b_mask), 32'b0101);
        check_value("pre-reset free_slots", 32'(free_slots), 32'd2);
        #1;
        reset = 1'b0;
        #1;
        check_value("midreset next_b_mask", 32'(next_b_mask), 32'd0);
        check_value("midreset free_slots", 32'(free_slots), 32'd4);
        check_value("midreset slot_b_mask0", 32'(slot_b_mask[0]), 32'd0);
        @(negedge clock);
        reset = 1'b1;

        apply_stimulus("post-reset", vecs[15]);
        check_output();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
